// File: rtl/bus_responder.sv
// Memory-mapped bus slave answering CPU requests from external ROM, internal RAM and one GPIO register.
// Optional macro BUS_ERROR_EN flags unmapped accesses and ROM writes on bus_error.
module bus_responder #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                ROM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] RAM_BASE    = 16'h8000,
  parameter int                RAM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFF00,
  parameter int                WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_address_out,
  input  logic [DATA_W-1:0] bus_data_out,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic [DATA_W-1:0] bus_data_in,
  output logic              bus_done,
  output logic              bus_error,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  // One extra bit so region limits at the top of the address space do not wrap.
  localparam logic [ADDR_W:0] ROM_END = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W:0] RAM_LO  = {1'b0, RAM_BASE};
  localparam logic [ADDR_W:0] RAM_END = RAM_LO + (ADDR_W+1)'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                is_write_reg;
  logic [3:0]          wait_cnt_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                done_reg;
  logic                error_reg;
  logic [ADDR_W-1:0]   rom_addr_reg;
  logic [DATA_W-1:0]   gpio_reg;
  logic                access_now;
  logic                hit_io, hit_ram, hit_rom;
  logic                err_c;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_idx;
  logic [DATA_W-1:0]   ram [RAM_DEPTH];

  // Decode on the latched address, priority IO > RAM > ROM.
  always_comb begin
    hit_io  = (addr_reg == IO_ADDR);
    hit_ram = !hit_io && ({1'b0, addr_reg} >= RAM_LO) && ({1'b0, addr_reg} < RAM_END);
    hit_rom = !hit_io && !hit_ram && ({1'b0, addr_reg} < ROM_END);
  end

  assign ram_idx = RAM_AW'(addr_reg - RAM_BASE);
  assign ram_we  = access_now && is_write_reg && hit_ram;

`ifdef BUS_ERROR_EN
  assign err_c = (!hit_io && !hit_ram && !hit_rom) || (hit_rom && is_write_reg);
`else
  assign err_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    access_now = 1'b0;
    unique case (state_reg)
      IDLE: if (bus_read || bus_write) state_next = WAIT;
      WAIT: if (wait_cnt_reg == 4'd0) begin
        state_next = DONE;
        access_now = 1'b1;
      end
      DONE: if (!bus_read && !bus_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      wait_cnt_reg <= 4'd0;
      rdata_reg    <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      rom_addr_reg <= '0;
      gpio_reg     <= '0;
    end else begin
      unique case (state_reg)
        IDLE: if (bus_read || bus_write) begin
          addr_reg     <= bus_address_out;
          wdata_reg    <= bus_data_out;
          is_write_reg <= bus_write && !bus_read;
          rom_addr_reg <= bus_address_out;
          wait_cnt_reg <= 4'(WAIT_STATES);
        end
        WAIT: if (wait_cnt_reg != 4'd0) begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end else begin
          done_reg  <= 1'b1;
          error_reg <= err_c;
          if (!is_write_reg) begin
            if (hit_io)       rdata_reg <= gpio_in;
            else if (hit_ram) rdata_reg <= ram[ram_idx];
            else if (hit_rom) rdata_reg <= rom_data;
            else              rdata_reg <= '0;
          end else if (hit_io) begin
            gpio_reg <= wdata_reg;
          end
        end
        DONE: if (!bus_read && !bus_write) begin
          done_reg  <= 1'b0;
          error_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM contents survive reset; the write enable is dead while the FSM is held in IDLE.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata_reg;
  end

  assign bus_data_in = rdata_reg;
  assign bus_done    = done_reg;
  assign bus_error   = error_reg;
  assign rom_addr    = rom_addr_reg;
  assign gpio_out    = gpio_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboarded bench for bus_responder: directed cases then random accesses against a memory-map model.
module tb_bus_responder;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_address_out = '0;
  logic [7:0]  bus_data_out = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [7:0]  bus_data_in;
  logic        bus_done;
  logic        bus_error;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;

  bus_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_in(bus_data_in), .bus_done(bus_done), .bus_error(bus_error),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    logic [7:0] data;
    logic       err;
    logic [15:0] ra;
    logic [7:0] gp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Reference model state
  logic [7:0] ram_m [256];
  bit         written [256];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] gpio_m = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one access to the memory map; returns the expected error flag.
  function automatic logic model(input logic [15:0] a, input bit wr, input logic [7:0] d,
                                 input bit both, input logic [7:0] rv, input logic [7:0] gv);
    bit eff_wr = wr && !both;
    bit io = (a == 16'hFF00);
    bit rm = (a >= 16'h8000) && (a < 16'h8100);
    bit ro = (a < 16'h0100);
    if (!eff_wr) begin
      if (io)      last_rd = gv;
      else if (rm) last_rd = ram_m[a - 16'h8000];
      else if (ro) last_rd = rv;
      else         last_rd = 8'h00;
    end else begin
      if (io) gpio_m = d;
      else if (rm) begin
        ram_m[a - 16'h8000] = d;
        written[a - 16'h8000] = 1'b1;
      end
    end
`ifdef BUS_ERROR_EN
    return (!io && !rm && !ro) || (ro && eff_wr);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every rising bus_done is matched against the oldest outstanding expectation.
  logic done_q = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus_done && !done_q) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.start, 1 + WS);
        chk("rdata", bus_data_in, e.data);
        chk("error", bus_error, e.err);
        chk("rom_addr", rom_addr, e.ra);
        chk("gpio_out", gpio_out, e.gp);
        $display("txn addr=%h data_in=%h err=%0d gpio_out=%h", e.ra, bus_data_in, bus_error, gpio_out);
      end
    end
    done_q = bus_done;
  end

  task automatic txn(input logic [15:0] a, input bit wr, input logic [7:0] d, input bit both,
                     input logic [7:0] rv, input logic [7:0] gv, input int hold, input bit drop);
    exp_t e;
    int n;
    @(negedge clk);
    bus_address_out = a;
    bus_data_out    = d;
    bus_read        = !wr || both;
    bus_write       = wr;
    rom_data        = rv;
    gpio_in         = gv;
    e.err   = model(a, wr, d, both, rv, gv);
    e.data  = last_rd;
    e.gp    = gpio_m;
    e.ra    = a;
    e.start = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    // Accepted by now: the bus may change freely without affecting the access.
    bus_address_out = 16'($urandom);
    bus_data_out    = 8'($urandom);
    if (drop) begin
      bus_read  = 1'b0;
      bus_write = 1'b0;
    end
    n = 0;
    while (!bus_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus_done, 1);
    if (!bus_done) q.delete();
    if (drop) begin
      @(posedge clk); #1;
      chk("drop_one_cycle", bus_done, 0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_done", bus_done, 1);
        chk("hold_data", bus_data_in, e.data);
      end
      @(negedge clk);
      bus_read  = 1'b0;
      bus_write = 1'b0;
      @(posedge clk); #1;
      chk("done_fall", bus_done, 0);
      chk("error_fall", bus_error, 0);
    end
  endtask

  initial begin
    logic [15:0] a;
    bit wr, both;
    int r, idx;
    for (int i = 0; i < 256; i++) begin
      ram_m[i] = 8'h00;
      written[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_done", bus_done, 0);
    chk("rst_error", bus_error, 0);
    chk("rst_data", bus_data_in, 0);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;

    txn(16'h0000, 1'b0, 8'h00, 1'b0, 8'h3E, 8'h00, 0, 1'b0);
    txn(16'h8010, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    txn(16'h8010, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    txn(16'hFF00, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    txn(16'hFF00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 0, 1'b0);
    txn(16'h4000, 1'b0, 8'h00, 1'b0, 8'h99, 8'h00, 0, 1'b0);
    txn(16'h0005, 1'b1, 8'hEE, 1'b0, 8'h12, 8'h00, 0, 1'b0);
    txn(16'h8010, 1'b1, 8'h66, 1'b1, 8'h00, 8'h00, 0, 1'b0);
    txn(16'h0042, 1'b0, 8'h00, 1'b0, 8'hC7, 8'h00, 10, 1'b0);
    txn(16'h8020, 1'b1, 8'h99, 1'b0, 8'h00, 8'h00, 0, 1'b1);
    txn(16'h8020, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    txn(16'h8000, 1'b1, 8'h11, 1'b0, 8'h00, 8'h00, 0, 1'b0);

    // Reset in the middle of a waiting write to 0x8000.
    @(negedge clk);
    bus_address_out = 16'h8000;
    bus_data_out    = 8'h77;
    bus_write       = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", bus_done, 0);
    chk("midrst_gpio", gpio_out, 0);
    chk("midrst_data", bus_data_in, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    last_rd = 8'h00;
    gpio_m  = 8'h00;
    bus_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(16'h8000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      r    = $urandom_range(0, 4);
      wr   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 255);
      case (r)
        0: a = 16'(idx);
        1, 4: a = 16'h8000 + 16'(idx);
        2: a = 16'hFF00;
        default: begin
          case ($urandom_range(0, 2))
            0: a = 16'($urandom_range(16'h0100, 16'h7FFF));
            1: a = 16'($urandom_range(16'h8100, 16'hFEFF));
            default: a = 16'($urandom_range(16'hFF01, 16'hFFFF));
          endcase
        end
      endcase
      if ((r == 1 || r == 4) && (!wr || both) && !written[idx]) begin
        wr = 1'b1;
        both = 1'b0;
      end
      txn(a, wr, 8'($urandom), both, 8'($urandom), 8'($urandom),
          ($urandom_range(0, 9) == 0) ? 2 : 0, ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
